// File: rtl/phase_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the sine generator's 16-bit phase accumulator.
// Steps increment_value from f_start to f_stop with a programmable dwell and pulses SCLR per sweep.
module phase_sweep_ctrl #(
    parameter int W  = 16,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    output logic [W-1:0]  increment_value,
    output logic          sclr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

    // A zero dwell still holds each value for one RUN cycle.
    function automatic logic [DW-1:0] dwell_eff(input logic [DW-1:0] d);
        dwell_eff = (d == {DW{1'b0}}) ? CNT_ONE : d;
    endfunction

    // Saturating step toward stop; a zero step means jump straight to stop.
    function automatic logic [W-1:0] step_next(
        input logic [W-1:0] cur,
        input logic [W-1:0] stop,
        input logic [W-1:0] step,
        input logic         up
    );
        logic [W:0] sum_s;
        logic [W:0] diff_s;
        sum_s  = {1'b0, cur} + {1'b0, step};
        diff_s = {1'b0, cur} - {1'b0, step};
        if (step == {W{1'b0}}) begin
            step_next = stop;
        end else if (up) begin
            if (sum_s[W] || (sum_s[W-1:0] > stop)) begin
                step_next = stop;
            end else begin
                step_next = sum_s[W-1:0];
            end
        end else begin
            if (diff_s[W] || (diff_s[W-1:0] < stop)) begin
                step_next = stop;
            end else begin
                step_next = diff_s[W-1:0];
            end
        end
    endfunction

    state_t        state_r, state_s;
    logic [W-1:0]  cur_r, cur_s;
    logic [DW-1:0] cnt_r, cnt_s;
    logic          latch_s;

    logic [W-1:0]  start_cfg_r;
    logic [W-1:0]  stop_cfg_r;
    logic [W-1:0]  step_cfg_r;
    logic [DW-1:0] dwell_cfg_r;
    logic          mode_cfg_r;
    logic          up_cfg_r;

    logic [W-1:0]  inc_r, inc_s;
    logic          sclr_r, sclr_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;

    // Next-state, current-value and dwell-counter decode.
    always_comb begin
        state_s = state_r;
        cur_s   = cur_r;
        cnt_s   = cnt_r;
        latch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    latch_s = 1'b1;
                    state_s = ST_CLEAR;
                    cur_s   = f_start;
                    cnt_s   = dwell_eff(dwell);
                end else begin
                    cur_s   = {W{1'b0}};
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    cur_s   = {W{1'b0}};
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    cur_s   = {W{1'b0}};
                end else if (cnt_r <= CNT_ONE) begin
                    if (cur_r == stop_cfg_r) begin
                        if (mode_cfg_r) begin
                            state_s = ST_CLEAR;
                            cur_s   = start_cfg_r;
                            cnt_s   = dwell_eff(dwell_cfg_r);
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        cur_s = step_next(cur_r, stop_cfg_r, step_cfg_r, up_cfg_r);
                        cnt_s = dwell_eff(dwell_cfg_r);
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cur_s   = {W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                cur_s   = {W{1'b0}};
            end
        endcase
    end

    // Output values follow the state being entered so the registered outputs line up with it.
    always_comb begin
        inc_s  = (state_s == ST_IDLE) ? {W{1'b0}} : cur_s;
        sclr_s = (state_s == ST_CLEAR);
        busy_s = (state_s == ST_CLEAR) || (state_s == ST_RUN);
        done_s = (state_s == ST_DONE);
    end

    // State, sweep position, dwell counter and registered outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= ST_IDLE;
            cur_r   <= {W{1'b0}};
            cnt_r   <= {DW{1'b0}};
            inc_r   <= {W{1'b0}};
            sclr_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cur_r   <= cur_s;
            cnt_r   <= cnt_s;
            inc_r   <= inc_s;
            sclr_r  <= sclr_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Sweep configuration captured once per start; untouched while a sweep runs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            start_cfg_r <= {W{1'b0}};
            stop_cfg_r  <= {W{1'b0}};
            step_cfg_r  <= {W{1'b0}};
            dwell_cfg_r <= {DW{1'b0}};
            mode_cfg_r  <= 1'b0;
            up_cfg_r    <= 1'b0;
        end else if (latch_s) begin
            start_cfg_r <= f_start;
            stop_cfg_r  <= f_stop;
            step_cfg_r  <= f_step;
            dwell_cfg_r <= dwell;
            mode_cfg_r  <= mode;
            up_cfg_r    <= (f_stop >= f_start);
        end else begin
            start_cfg_r <= start_cfg_r;
            stop_cfg_r  <= stop_cfg_r;
            step_cfg_r  <= step_cfg_r;
            dwell_cfg_r <= dwell_cfg_r;
            mode_cfg_r  <= mode_cfg_r;
            up_cfg_r    <= up_cfg_r;
        end
    end

    assign increment_value = inc_r;
    assign sclr            = sclr_r;
    assign busy            = busy_r;
    assign done            = done_r;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Scoreboard bench for phase_sweep_ctrl: expected output cycles are queued with each start
// and a negedge monitor pops one entry whenever busy or done is high.
module tb_phase_sweep_ctrl;

    localparam int W  = 16;
    localparam int DW = 16;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          abort;
    logic          mode;
    logic [W-1:0]  f_start;
    logic [W-1:0]  f_stop;
    logic [W-1:0]  f_step;
    logic [DW-1:0] dwell;
    logic [W-1:0]  increment_value;
    logic          sclr;
    logic          busy;
    logic          done;

    typedef struct packed {
        logic [W-1:0] inc;
        logic         sclr;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;

    phase_sweep_ctrl #(.W(W), .DW(DW)) dut (
        .CLK             (clk),
        .RSTN            (rstn),
        .start           (start),
        .abort           (abort),
        .mode            (mode),
        .f_start         (f_start),
        .f_stop          (f_stop),
        .f_step          (f_step),
        .dwell           (dwell),
        .increment_value (increment_value),
        .sclr            (sclr),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every active output cycle must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && (busy || done)) begin
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_output t=%0t inc=%0d sclr=%0b busy=%0b done=%0b required=idle",
                         $time, increment_value, sclr, busy, done);
            end else begin
                e = q.pop_front();
                if (increment_value !== e.inc || sclr !== e.sclr || busy !== e.busy || done !== e.done) begin
                    bad = bad + 1;
                    $display("FAIL seq t=%0t got inc=%0d sclr=%0b busy=%0b done=%0b required inc=%0d sclr=%0b busy=%0b done=%0b",
                             $time, increment_value, sclr, busy, done, e.inc, e.sclr, e.busy, e.done);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] inc, input logic s, input logic b, input logic d);
        exp_t e;
        e.inc  = inc;
        e.sclr = s;
        e.busy = b;
        e.done = d;
        q.push_back(e);
    endtask

    task automatic push_run(input logic [W-1:0] v, input int n);
        for (int i = 0; i < n; i++) push(v, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic cfg(input logic [W-1:0] fs, input logic [W-1:0] fe, input logic [W-1:0] st,
                       input logic [DW-1:0] dw, input logic md);
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        mode    = md;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_inc"},  32'(increment_value), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_sclr"}, 32'(sclr), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_timeout pending=%0d required=0", name, q.size());
            q.delete();
        end
        @(posedge clk);
        #1 check_idle(name);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rstn    = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        cfg(16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_idle("reset");
        rstn = 1'b1;

        // Basic up sweep; a mid-sweep start with new inputs must change nothing.
        cfg(16'd100, 16'd400, 16'd100, 16'd3, 1'b0);
        push(16'd100, 1'b1, 1'b1, 1'b0);
        push_run(16'd100, 3);
        push_run(16'd200, 3);
        push_run(16'd300, 3);
        push_run(16'd400, 3);
        push(16'd400, 1'b0, 1'b0, 1'b1);
        pulse_start();
        repeat (4) @(posedge clk);
        #1 cfg(16'd7, 16'd9, 16'd1, 16'd0, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        drain("up");

        // Down sweep clamps to stop.
        cfg(16'd1000, 16'd250, 16'd400, 16'd1, 1'b0);
        push(16'd1000, 1'b1, 1'b1, 1'b0);
        push_run(16'd1000, 1);
        push_run(16'd600, 1);
        push_run(16'd250, 1);
        push(16'd250, 1'b0, 1'b0, 1'b1);
        pulse_start();
        drain("down");

        // Carry out of the top bit must clamp, not wrap.
        cfg(16'hFF00, 16'hFFF0, 16'h0200, 16'd2, 1'b0);
        push(16'hFF00, 1'b1, 1'b1, 1'b0);
        push_run(16'hFF00, 2);
        push_run(16'hFFF0, 2);
        push(16'hFFF0, 1'b0, 1'b0, 1'b1);
        pulse_start();
        drain("ovf");

        // Zero step and zero dwell.
        cfg(16'd5, 16'd9, 16'd0, 16'd0, 1'b0);
        push(16'd5, 1'b1, 1'b1, 1'b0);
        push_run(16'd5, 1);
        push_run(16'd9, 1);
        push(16'd9, 1'b0, 1'b0, 1'b1);
        pulse_start();
        drain("zero");

        // Equal start and stop: one dwell then done.
        cfg(16'd77, 16'd77, 16'd3, 16'd2, 1'b0);
        push(16'd77, 1'b1, 1'b1, 1'b0);
        push_run(16'd77, 2);
        push(16'd77, 1'b0, 1'b0, 1'b1);
        pulse_start();
        drain("equal");

        // Repeat mode, aborted during the second sweep.
        cfg(16'd10, 16'd30, 16'd10, 16'd1, 1'b1);
        push(16'd10, 1'b1, 1'b1, 1'b0);
        push_run(16'd10, 1);
        push_run(16'd20, 1);
        push_run(16'd30, 1);
        push(16'd10, 1'b1, 1'b1, 1'b0);
        push_run(16'd10, 1);
        pulse_start();
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_idle("abort");
        chk("abort_pending", 32'(q.size()), 32'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1 check_idle("abort_after");

        // Start together with abort in IDLE is ignored.
        cfg(16'd1, 16'd2, 16'd1, 16'd1, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_idle("start_abort");

        // Asynchronous reset in the middle of RUN.
        cfg(16'd100, 16'd400, 16'd100, 16'd3, 1'b0);
        push(16'd100, 1'b1, 1'b1, 1'b0);
        push_run(16'd100, 3);
        push_run(16'd200, 3);
        pulse_start();
        repeat (4) @(posedge clk);
        #2 rstn = 1'b0;
        #1 check_idle("async_rst");
        q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sweep_ctrl.md
Name: phase_sweep_ctrl

Overview:
- Sequences the 16-bit phase accumulator of the sine wave generator.
- Performs a linear frequency sweep: drives the accumulator's increment_value from f_start to f_stop in steps of f_step, holding each value for a programmable dwell.
- Issues the accumulator's synchronous clear (SCLR) at the start of every sweep.
- Sits between the register/config interface and the phase accumulator; supports single-shot or continuous-repeat sweeps.

Parameters:
W, 16, width of frequency words and of increment_value (matches the accumulator)
DW, 16, width of the dwell count

Ports:
CLK  in  1  system clock, rising edge
RSTN  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep; ignored unless IDLE
abort  in  1  stop immediately and return to IDLE
mode  in  1  0 = single sweep, 1 = repeat continuously
f_start  in  W  first increment value
f_stop  in  W  final increment value
f_step  in  W  step magnitude
dwell  in  DW  RUN cycles spent at each value
increment_value  out  W  to accumulator increment_value
sclr  out  1  to accumulator SCLR, active high
busy  out  1  high in CLEAR and RUN
done  out  1  one-cycle pulse when a single sweep completes

Behaviour:
- Reset: RSTN low asynchronously forces IDLE. increment_value=0, sclr=0, busy=0, done=0. All latched configuration cleared.
- Outputs are registered.
- States are IDLE, CLEAR, RUN, DONE.
- IDLE:
  - increment_value=0.
  - start=1 and abort=0 at a clock edge: latch f_start/f_stop/f_step/dwell/mode, then go to CLEAR.
  - Input changes after the latch have no effect until the next start.
- CLEAR (1 cycle): sclr=1, increment_value=f_start latched, busy=1, dwell counter loaded. Then go to RUN.
- RUN:
  - sclr=0.
  - The current value is held for exactly max(dwell,1) cycles; dwell=0 is treated as 1.
  - When the dwell expires and current != stop: current steps toward stop, and the dwell counter reloads.
  - When the dwell expires and current == stop: mode=1 goes to CLEAR (new sweep, sclr pulse); mode=0 goes to DONE.
- DONE (1 cycle): done=1, busy=0, increment_value holds f_stop. Then go to IDLE.
- Direction:
  - Up sweep if f_stop >= f_start, otherwise down sweep.
  - f_start == f_stop: a single dwell at that value, then completion.
- Step arithmetic, computed at W+1 bits:
  - Up: next = cur + step. If the carry is set or next > stop, next = stop.
  - Down: next = cur - step. If a borrow occurs or next < stop, next = stop.
  - f_step=0 is treated as an infinite step, so the sweep jumps directly to stop after the first dwell.
  - The final value always equals f_stop exactly; there is no overshoot and no wrap-around.
- abort:
  - In any non-IDLE state: go to IDLE on the next edge. increment_value=0, sclr=0, busy=0, no done pulse.
  - abort has priority over start and over every RUN transition.
  - start and abort in the same IDLE cycle: remain in IDLE.
- start while not IDLE: ignored, with no relatch.
- RSTN asserted mid-sweep: immediate IDLE with reset values; no done pulse.

Test Plan:
- Reset: RSTN=0 mid-RUN -> outputs are 0 asynchronously, before the next CLK edge; after release, state is IDLE and increment_value=0.
- Basic up sweep: f_start=100, f_stop=400, f_step=100, dwell=3, mode=0, start pulse -> required response:
  - sclr=1 for 1 cycle with increment_value=100.
  - Then increment_value = 100 x3, 200 x3, 300 x3, 400 x3 cycles.
  - Then a done pulse with increment_value=400, then 0; busy high for 13 cycles.
- Clamp/down: f_start=1000, f_stop=250, f_step=400, dwell=1 -> 1000 (CLEAR), 1000, 600, 250, then done. The down sweep clamps to 250; no wrap to 0xFFxx.
- Overflow guard: f_start=0xFF00, f_stop=0xFFF0, f_step=0x0200, dwell=2 -> 0xFF00 x(1+2), then 0xFFF0 x2, then done. There is no 16-bit wrap.
- Repeat and abort:
  - mode=1, f_start=10, f_stop=30, f_step=10, dwell=1 -> 10, 10, 20, 30, then sclr pulse with 10, and the sequence repeats; done is never asserted.
  - abort in the second sweep -> IDLE next edge, increment_value=0, busy=0, no done.
- Corner inputs:
  - f_step=0, dwell=0, f_start=5, f_stop=9 -> CLEAR(5), 5 x1, 9 x1, then done.
  - start asserted during RUN -> no effect on the sequence.
  - start with abort in IDLE -> stays IDLE.
